// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock and
// ripples the carry between chunks through a register.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]         chunk_full;
    logic [CHUNK-1:0]       chunk_sum;
    logic                   chunk_c;
    logic                   msb_cin;
    logic [WIDTH+CHUNK-1:0] res_shift;
    logic [WIDTH-1:0]       res_next;
    logic                   last;

    always_comb begin
        chunk_full = {1'b0, a_q[CHUNK-1:0]}
                   + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        chunk_sum  = chunk_full[CHUNK-1:0];
        chunk_c    = chunk_full[CHUNK];
        // Carry into the top bit recovered from its sum bit.
        msb_cin    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
        res_shift  = {chunk_sum, res_q};
        res_next   = res_shift[WIDTH+CHUNK-1:CHUNK];
        last       = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ^ cin;
                    sub_d   = sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_next;
                carry_d = chunk_c;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d  = res_next;
                    cout_d = chunk_c ^ sub_q;
                    ovf_d  = msb_cin ^ chunk_c;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 32/8 and 8/8 instances checked against an
// arithmetic reference model with random operands and backpressure.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv0, ir0, ov0, or0, ci0, sb0, co0, of0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, ov1, or1, ci1, sb1, co1, of1;
    logic [7:0]  a1, b1, s1;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(ci0), .sub(sb0),
        .out_valid(ov0), .out_ready(or0),
        .sum(s0), .cout(co0), .ovf(of0)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(ci1), .sub(sb1),
        .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .ovf(of1)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cur = 1'b0;

    logic        obs_ir, obs_ov, obs_co, obs_of;
    logic [31:0] obs_sum;

    always_comb begin
        obs_ir  = cur ? ir1 : ir0;
        obs_ov  = cur ? ov1 : ov0;
        obs_co  = cur ? co1 : co0;
        obs_of  = cur ? of1 : of0;
        obs_sum = cur ? {24'h0, s1} : s0;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' numeric values.
    function automatic void model(input int w, input logic [31:0] av,
                                  input logic [31:0] bv, input bit ci,
                                  input bit sbt, output logic [31:0] s,
                                  output bit co, output bit of);
        longint m, ua, ub, c, r, sa, sbv, sr, hi, lo;
        m  = (longint'(1) << w) - 1;
        ua = longint'(av) & m;
        ub = longint'(bv) & m;
        c  = ci ? 1 : 0;
        r  = sbt ? (ua - ub - c) : (ua + ub + c);
        s  = 32'(r & m);
        co = sbt ? (r < 0) : (((r >> w) & 1) != 0);
        sa  = ua;
        sbv = ub;
        if (((ua >> (w - 1)) & 1) != 0) sa  = ua - (longint'(1) << w);
        if (((ub >> (w - 1)) & 1) != 0) sbv = ub - (longint'(1) << w);
        sr = sbt ? (sa - sbv - c) : (sa + sbv + c);
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        of = (sr > hi) || (sr < lo);
    endfunction

    task automatic set_in(input bit v, input logic [31:0] av,
                          input logic [31:0] bv, input bit c, input bit s);
        if (cur) begin
            iv1 = v; a1 = av[7:0]; b1 = bv[7:0]; ci1 = c; sb1 = s;
        end else begin
            iv0 = v; a0 = av; b0 = bv; ci0 = c; sb0 = s;
        end
    endtask

    task automatic set_ordy(input bit v);
        if (cur) or1 = v;
        else or0 = v;
    endtask

    task automatic junk_in(input bit v);
        set_in(v, $urandom, $urandom, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         input bit ci, input bit sbt, input int bp);
        int n, w, lat;
        logic [31:0] es;
        bit ec, eo;
        n = cur ? 1 : 4;
        w = cur ? 8 : 32;
        model(w, av, bv, ci, sbt, es, ec, eo);
        @(negedge clk);
        chk("in_ready_idle", obs_ir, 1);
        set_in(1'b1, av, bv, ci, sbt);
        @(posedge clk);
        @(negedge clk);
        junk_in(1'b0);
        lat = 0;
        while (!obs_ov && lat < 20) begin
            junk_in(1'($urandom));
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(n));
        chk("sum", obs_sum, es);
        chk("cout", obs_co, ec);
        chk("ovf", obs_of, eo);
        chk("in_ready_done", obs_ir, 0);
        repeat (bp) begin
            junk_in(1'b1);
            @(negedge clk);
            chk("hold_sum", obs_sum, es);
            chk("hold_in_ready", obs_ir, 0);
            chk("hold_out_valid", obs_ov, 1);
        end
        junk_in(1'b0);
        set_ordy(1'b1);
        @(negedge clk);
        set_ordy(1'b0);
        chk("in_ready_after_hs", obs_ir, 1);
        chk("out_valid_after_hs", obs_ov, 0);
        chk("sum_after_hs", obs_sum, es);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        iv0 = 0; a0 = '0; b0 = '0; ci0 = 0; sb0 = 0; or0 = 0;
        iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; sb1 = 0; or1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready0", ir0, 1);
        chk("rst_out_valid0", ov0, 0);
        chk("rst_sum0", s0, 0);
        chk("rst_cout0", co0, 0);
        chk("rst_ovf0", of0, 0);
        chk("rst_in_ready1", ir1, 1);
        chk("rst_out_valid1", ov1, 0);
        chk("rst_sum1", s1, 0);
        rst = 1'b0;

        cur = 1'b0;
        do_op(32'h0000_00FF, 32'h0000_0001, 0, 0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 1, 0, 0);
        do_op(32'h0000_0005, 32'h0000_0007, 0, 1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 0, 1, 0);
        do_op(32'h1234_5678, 32'h0FED_CBA9, 1, 1, 3);

        // Abort in the second RUN cycle: nothing may come out afterwards.
        @(negedge clk);
        set_in(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, '0, '0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", ir0, 1);
        chk("abort_out_valid", ov0, 0);
        chk("abort_sum", s0, 0);
        chk("abort_cout", co0, 0);
        chk("abort_ovf", of0, 0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_result", ov0, 0);
        end

        for (int i = 0; i < 30; i++)
            do_op(pick32(), pick32(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3));

        cur = 1'b1;
        do_op(32'h97, 32'h01, 0, 0, 0);
        do_op(32'h7F, 32'h01, 0, 0, 0);
        do_op(32'h80, 32'h01, 0, 1, 1);
        for (int i = 0; i < 20; i++)
            do_op(pick32(), pick32(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
